// File: rtl/fft_seq_counter.sv
// Modulo-MODULUS up/down address counter with load, bit-reversed output and a
// multi-pass run/done sequencer for radix-2 FFT address generation.
module fft_seq_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16,
    parameter int unsigned PASSES  = 1
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             start,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_rev,
    output logic             cout,
    output logic [7:0]       pass_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    CW        = WIDTH + 1;
    localparam logic [WIDTH-1:0] TERM_HI = WIDTH'(MODULUS - 1);
    localparam logic [CW-1:0]  MOD_EXT   = CW'(MODULUS);
    localparam logic [7:0]     PASS_LAST = 8'(PASSES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic [7:0]       pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CW-1:0]    cnt_ext;
    logic [CW-1:0]    step_ext;
    logic [WIDTH-1:0] step_val;
    logic             wrap;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] init_val;
    logic [7:0]       pass_inc;

    // Next count one step in the direction sampled this cycle, widened by a bit.
    always_comb begin
        cnt_ext  = {1'b0, out_q};
        step_ext = '0;
        wrap     = 1'b0;
        if (!dir) begin
            wrap     = (out_q == TERM_HI);
            step_ext = wrap ? '0 : cnt_ext + CW'(1);
        end else begin
            wrap     = (out_q == '0);
            step_ext = wrap ? {1'b0, TERM_HI} : cnt_ext - CW'(1);
        end
        step_val     = WIDTH'(step_ext);
        load_clamped = ({1'b0, load_val} >= MOD_EXT) ? TERM_HI : load_val;
        init_val     = dir ? TERM_HI : '0;
        pass_inc     = pass_q + 8'd1;
    end

    // Sequencer and count next-state.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cout_d  = 1'b0;
        pass_d  = pass_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    out_d   = init_val;
                    pass_d  = 8'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (load) begin
                    out_d = load_clamped;
                end else if (en) begin
                    out_d = step_val;
                    if (wrap) begin
                        cout_d = 1'b1;
                        pass_d = pass_inc;
                        if (pass_inc == PASS_LAST) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            cout_q  <= 1'b0;
            pass_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Bit-reversed view straight off the count register.
    always_comb begin
        out_rev = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            out_rev[i] = out_q[int'(WIDTH) - 1 - i];
        end
    end

    assign out      = out_q;
    assign cout     = cout_q;
    assign pass_idx = pass_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
